// File: rtl/jt12_pg_pm.sv
// rtl/jt12_pg_pm.sv - FM phase generator with LFO phase modulation
// Eight-stage pipeline, one operator slot per clock, circulating per-slot accumulators.
module jt12_pg_pm #(
  parameter int SLOTS = 24,
  parameter int PHW   = 20,
  parameter int OUTW  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     fnum_I,
  input  logic [2:0]      block_I,
  input  logic [7:0]      pm_I,
  input  logic [2:0]      pms_I,
  input  logic [2:0]      dt1_II,
  input  logic [3:0]      mul_V,
  input  logic            pg_rst_III,
  input  logic            pg_stop,
  output logic [4:0]      keycode_III,
  output logic [OUTW-1:0] phase_VIII
);

  // stage I: phase modulation and block shift
  logic signed [7:0]  pm_scaled;
  logic signed [19:0] pm_prod;
  logic [11:0]        fnum_pm;
  logic [7:0]         pm_frac_unused;
  logic [17:0]        phinc_ii_d, phinc_ii_q;
  logic [4:0]         keycode_ii_d, keycode_ii_q;

  always_comb begin
    pm_scaled = 8'sd0;
    if (pms_I != 3'd0)
      pm_scaled = $signed(pm_I) >>> (3'd7 - pms_I);
    pm_prod = $signed({9'd0, fnum_I}) * $signed({{12{pm_scaled[7]}}, pm_scaled});
    // Adding fnum<<8 before dropping the fraction gives fnum + floor(prod/256).
    {fnum_pm, pm_frac_unused} = {1'b0, fnum_I, 8'd0} + pm_prod;
    if (block_I == 3'd0)
      phinc_ii_d = {7'd0, fnum_pm[11:1]};
    else
      phinc_ii_d = {6'd0, fnum_pm} << (block_I - 3'd1);
    keycode_ii_d = {block_I, fnum_I[10],
                    fnum_I[10] ? |fnum_I[9:7] : &fnum_I[9:7]};
  end

  // stage II: detune keycode
  logic [5:0]  dt_add;
  logic [5:0]  kf_iii_d, kf_iii_q;
  logic [17:0] phinc_iii_d, phinc_iii_q;
  logic [4:0]  keycode_iii_d, keycode_iii_q;
  logic [2:0]  dt1_iii_d, dt1_iii_q;

  always_comb begin
    case (dt1_II[1:0])
      2'd1:    dt_add = 6'd60;
      2'd2:    dt_add = 6'd4;
      2'd3:    dt_add = 6'd8;
      default: dt_add = 6'd0;
    endcase
    kf_iii_d      = {1'b0, keycode_ii_q} + dt_add;
    phinc_iii_d   = phinc_ii_q;
    keycode_iii_d = keycode_ii_q;
    dt1_iii_d     = dt1_II;
  end

  // stage III: detune offset, clamped per magnitude code
  logic [5:0]  pow2, unlimited, limit;
  logic [4:0]  offset_iv_d, offset_iv_q;
  logic [17:0] phinc_iv_d, phinc_iv_q;
  logic [2:0]  dt1_iv_d, dt1_iv_q;
  logic        pg_rst_iv_d, pg_rst_iv_q;

  always_comb begin
    case (kf_iii_q[2:0])
      3'd0:    pow2 = 6'd16;
      3'd1:    pow2 = 6'd17;
      3'd2:    pow2 = 6'd19;
      3'd3:    pow2 = 6'd20;
      3'd4:    pow2 = 6'd22;
      3'd5:    pow2 = 6'd24;
      3'd6:    pow2 = 6'd26;
      default: pow2 = 6'd29;
    endcase
    case (kf_iii_q[5:3])
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: unlimited = pow2 >> (3'd4 - kf_iii_q[5:3]);
      3'd5:                          unlimited = pow2 << 1;
      default:                       unlimited = 6'd0;
    endcase
    case (dt1_iii_q[1:0])
      2'd2:    limit = 6'd16;
      2'd3:    limit = 6'd22;
      default: limit = 6'd8;
    endcase
    offset_iv_d = (unlimited < limit) ? unlimited[4:0] : limit[4:0];
    phinc_iv_d  = phinc_iii_q;
    dt1_iv_d    = dt1_iii_q;
    pg_rst_iv_d = pg_rst_III;
  end

  // stage IV: apply detune
  logic [17:0] phinc_v_d, phinc_v_q;
  logic        pg_rst_v_d, pg_rst_v_q;

  always_comb begin
    phinc_v_d = phinc_iv_q;
    if (dt1_iv_q[1:0] != 2'd0)
      phinc_v_d = dt1_iv_q[2] ? phinc_iv_q - {13'd0, offset_iv_q}
                              : phinc_iv_q + {13'd0, offset_iv_q};
    pg_rst_v_d = pg_rst_iv_q;
  end

  // stage V: multiplier, zero means one half
  logic [17:0] phinc_vi_d, phinc_vi_q;
  logic        pg_rst_vi_d, pg_rst_vi_q;

  always_comb begin
    if (mul_V == 4'd0)
      phinc_vi_d = {1'b0, phinc_v_q[17:1]};
    else
      phinc_vi_d = phinc_v_q * {14'd0, mul_V};
    pg_rst_vi_d = pg_rst_v_q;
  end

  // stage VI: accumulate into the circulating phase memory
  logic [PHW-1:0]  mem_d [SLOTS];
  logic [PHW-1:0]  mem_q [SLOTS];
  logic [PHW-1:0]  acc_old, acc_new;
  logic [OUTW-1:0] phase_vii_d, phase_vii_q;
  logic [OUTW-1:0] phase_viii_d, phase_viii_q;

  always_comb begin
    acc_old = mem_q[SLOTS-1];
    if (pg_rst_vi_q)
      acc_new = '0;
    else if (pg_stop)
      acc_new = acc_old;
    else
      acc_new = acc_old + PHW'(phinc_vi_q);
    mem_d[0] = acc_new;
    for (int i = 1; i < SLOTS; i++)
      mem_d[i] = mem_q[i-1];
    phase_vii_d  = acc_new[PHW-1 -: OUTW];
    phase_viii_d = phase_vii_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phinc_ii_q    <= '0;
      keycode_ii_q  <= '0;
      kf_iii_q      <= '0;
      phinc_iii_q   <= '0;
      keycode_iii_q <= '0;
      dt1_iii_q     <= '0;
      offset_iv_q   <= '0;
      phinc_iv_q    <= '0;
      dt1_iv_q      <= '0;
      pg_rst_iv_q   <= 1'b0;
      phinc_v_q     <= '0;
      pg_rst_v_q    <= 1'b0;
      phinc_vi_q    <= '0;
      pg_rst_vi_q   <= 1'b0;
      phase_vii_q   <= '0;
      phase_viii_q  <= '0;
      for (int i = 0; i < SLOTS; i++)
        mem_q[i] <= '0;
    end else begin
      phinc_ii_q    <= phinc_ii_d;
      keycode_ii_q  <= keycode_ii_d;
      kf_iii_q      <= kf_iii_d;
      phinc_iii_q   <= phinc_iii_d;
      keycode_iii_q <= keycode_iii_d;
      dt1_iii_q     <= dt1_iii_d;
      offset_iv_q   <= offset_iv_d;
      phinc_iv_q    <= phinc_iv_d;
      dt1_iv_q      <= dt1_iv_d;
      pg_rst_iv_q   <= pg_rst_iv_d;
      phinc_v_q     <= phinc_v_d;
      pg_rst_v_q    <= pg_rst_v_d;
      phinc_vi_q    <= phinc_vi_d;
      pg_rst_vi_q   <= pg_rst_vi_d;
      phase_vii_q   <= phase_vii_d;
      phase_viii_q  <= phase_viii_d;
      for (int i = 0; i < SLOTS; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  assign keycode_III = keycode_iii_q;
  assign phase_VIII  = phase_viii_q;

endmodule

// File: tb/tb_jt12_pg_pm.sv
// tb/tb_jt12_pg_pm.sv - scoreboard bench for jt12_pg_pm
// Default instance plus a full-width-output instance so accumulator LSBs are observable.
`timescale 1ns/1ps
module tb_jt12_pg_pm;
  localparam int SLOTS = 24;
  localparam int PHW   = 20;
  localparam int OUTW  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] fnum_I;
  logic [2:0]  block_I;
  logic [7:0]  pm_I;
  logic [2:0]  pms_I;
  logic [2:0]  dt1_II;
  logic [3:0]  mul_V;
  logic        pg_rst_III;
  logic        pg_stop;
  logic [4:0]  keycode_III, keycode_w;
  logic [OUTW-1:0] phase_VIII;
  logic [PHW-1:0]  phase_w;

  jt12_pg_pm #(.SLOTS(SLOTS), .PHW(PHW), .OUTW(OUTW)) dut (
    .clk(clk), .rst(rst), .fnum_I(fnum_I), .block_I(block_I), .pm_I(pm_I),
    .pms_I(pms_I), .dt1_II(dt1_II), .mul_V(mul_V), .pg_rst_III(pg_rst_III),
    .pg_stop(pg_stop), .keycode_III(keycode_III), .phase_VIII(phase_VIII));

  jt12_pg_pm #(.SLOTS(SLOTS), .PHW(PHW), .OUTW(PHW)) dut_w (
    .clk(clk), .rst(rst), .fnum_I(fnum_I), .block_I(block_I), .pm_I(pm_I),
    .pms_I(pms_I), .dt1_II(dt1_II), .mul_V(mul_V), .pg_rst_III(pg_rst_III),
    .pg_stop(pg_stop), .keycode_III(keycode_w), .phase_VIII(phase_w));

  always #5 clk = ~clk;

  typedef struct {
    int fnum; int block; int pm; int pms; int dt1; int mul; int pgrst; int stop;
  } txn_t;
  typedef struct { int due; longint val; } exp_t;

  int pow2_tab [8] = '{16, 17, 19, 20, 22, 24, 26, 29};
  int dt_add_tab [4] = '{0, -4, 4, 8};
  int limit_tab [4] = '{8, 8, 16, 22};

  txn_t   hist [8];
  txn_t   zero_txn;
  longint acc [SLOTS];
  exp_t   keyq[$];
  exp_t   phq[$];
  exp_t   wq[$];
  int     cyc = 0;
  int     tsr = 0;
  int     checks = 0;
  int     failures = 0;

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int calc_key(txn_t x);
    int top3;
    int lsb;
    top3 = (x.fnum / 128) % 8;
    if (x.fnum >= 1024) lsb = (top3 != 0) ? 1 : 0;
    else                lsb = (top3 == 7) ? 1 : 0;
    return x.block * 4 + ((x.fnum >= 1024) ? 2 : 0) + lsb;
  endfunction

  function automatic int calc_phinc(txn_t x);
    int sc, fpm, ph, kf, oct, unl, off;
    sc  = (x.pms == 0) ? 0 : floor_div(x.pm, 1 << (7 - x.pms));
    fpm = x.fnum + floor_div(x.fnum * sc, 256);
    ph  = (x.block == 0) ? fpm / 2 : fpm * (1 << (x.block - 1));
    kf  = (calc_key(x) + dt_add_tab[x.dt1 % 4] + 64) % 64;
    oct = kf / 8;
    if (oct <= 4)      unl = pow2_tab[kf % 8] / (1 << (4 - oct));
    else if (oct == 5) unl = pow2_tab[kf % 8] * 2;
    else               unl = 0;
    off = (unl < limit_tab[x.dt1 % 4]) ? unl : limit_tab[x.dt1 % 4];
    if (x.dt1 % 4 != 0) ph = (x.dt1 >= 4) ? ph - off : ph + off;
    ph = ((ph % 262144) + 262144) % 262144;
    ph = (x.mul == 0) ? ph / 2 : (ph * x.mul) % 262144;
    return ph;
  endfunction

  task automatic cmp(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic drive(input txn_t x, input bit push);
    txn_t p;
    int   ph;
    int   s;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    hist[tsr % 8] = x;
    fnum_I  = 11'(x.fnum);
    block_I = 3'(x.block);
    pm_I    = 8'(x.pm);
    pms_I   = 3'(x.pms);
    p = (tsr >= 1) ? hist[(tsr - 1) % 8] : zero_txn;
    dt1_II = 3'(p.dt1);
    p = (tsr >= 2) ? hist[(tsr - 2) % 8] : zero_txn;
    pg_rst_III = p.pgrst[0];
    p = (tsr >= 4) ? hist[(tsr - 4) % 8] : zero_txn;
    mul_V = 4'(p.mul);
    p = (tsr >= 5) ? hist[(tsr - 5) % 8] : zero_txn;
    pg_stop = p.stop[0];
    if (push) begin
      s  = tsr % SLOTS;
      ph = calc_phinc(x);
      if (x.pgrst != 0)     acc[s] = 0;
      else if (x.stop == 0) acc[s] = (acc[s] + longint'(ph)) % (64'sd1 << PHW);
      keyq.push_back('{cyc + 2, longint'(calc_key(x))});
      phq.push_back('{cyc + 7, acc[s] >> (PHW - OUTW)});
      wq.push_back('{cyc + 7, acc[s]});
    end
    tsr++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    fnum_I = '0; block_I = '0; pm_I = '0; pms_I = '0;
    dt1_II = '0; mul_V = '0; pg_rst_III = 1'b0; pg_stop = 1'b0;
    keyq.delete(); phq.delete(); wq.delete();
    for (int i = 0; i < SLOTS; i++) acc[i] = 0;
    tsr = 0;
    for (int k = 1; k <= 2; k++) keyq.push_back('{cyc + k, 64'sd0});
    for (int k = 1; k <= 7; k++) begin
      phq.push_back('{cyc + k, 64'sd0});
      wq.push_back('{cyc + k, 64'sd0});
    end
  endtask

  function automatic txn_t mk(int fnum, int block, int pm, int pms, int dt1, int mul,
                              int pgrst, int stop);
    txn_t x;
    x.fnum = fnum; x.block = block; x.pm = pm; x.pms = pms;
    x.dt1 = dt1; x.mul = mul; x.pgrst = pgrst; x.stop = stop;
    return x;
  endfunction

  function automatic txn_t rand_txn();
    return mk($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 255) - 128,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15),
              ($urandom_range(0, 31) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
  endfunction

  // Monitor: pops every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (keyq.size() != 0 && keyq[0].due <= cyc) begin
      e = keyq.pop_front();
      if (e.due < cyc) cmp("keycode_missed", longint'(e.due), longint'(cyc));
      else begin
        cmp("keycode_III", longint'(keycode_III), e.val);
        cmp("keycode_III_w", longint'(keycode_w), e.val);
      end
    end
    while (phq.size() != 0 && phq[0].due <= cyc) begin
      e = phq.pop_front();
      if (e.due < cyc) cmp("phase_missed", longint'(e.due), longint'(cyc));
      else cmp("phase_VIII", longint'(phase_VIII), e.val);
    end
    while (wq.size() != 0 && wq[0].due <= cyc) begin
      e = wq.pop_front();
      if (e.due < cyc) cmp("acc_missed", longint'(e.due), longint'(cyc));
      else cmp("phase_full", longint'(phase_w), e.val);
    end
  end

  initial begin
    zero_txn = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) hist[i] = zero_txn;
    rst = 1'b1;
    fnum_I = '0; block_I = '0; pm_I = '0; pms_I = '0;
    dt1_II = '0; mul_V = '0; pg_rst_III = 1'b0; pg_stop = 1'b0;

    do_reset();
    repeat (SLOTS) drive(zero_txn, 1'b1);

    // basic increment long enough to wrap the 10-bit phase
    repeat (130 * SLOTS) drive(mk(1024, 4, 0, 0, 0, 1, 0, 0), 1'b1);
    repeat (2 * SLOTS) drive(mk(1024, 4, 0, 0, 0, 0, 0, 0), 1'b1);
    repeat (4 * SLOTS) drive(mk(1024, 4, 0, 0, 0, 15, 0, 0), 1'b1);

    // detune, including a clamped offset
    repeat (3 * SLOTS) drive(mk(1024, 4, 0, 0, 1, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(1024, 4, 0, 0, 5, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(1024, 4, 0, 0, 3, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(2047, 7, 0, 0, 3, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(2047, 7, 0, 0, 7, 1, 0, 0), 1'b1);

    // phase modulation extremes
    repeat (3 * SLOTS) drive(mk(1024, 4, 127, 7, 0, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(1024, 4, -128, 7, 0, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(1024, 4, $urandom_range(0, 255) - 128, 0, 0, 1, 0, 0), 1'b1);
    repeat (3 * SLOTS) drive(mk(2047, 0, -128, 7, 0, 1, 0, 0), 1'b1);

    // hold one slot, then reset-with-stop on another
    for (int i = 0; i < 4 * SLOTS; i++)
      drive(mk(1024, 4, 0, 0, 0, 3, 0, (tsr % SLOTS == 5) ? 1 : 0), 1'b1);
    for (int i = 0; i < 2 * SLOTS; i++)
      drive(mk(1024, 4, 0, 0, 0, 3, (tsr % SLOTS == 7) ? 1 : 0,
               (tsr % SLOTS == 7) ? 1 : 0), 1'b1);

    repeat (2000) drive(rand_txn(), 1'b1);

    // reset in the middle of traffic
    do_reset();
    repeat (SLOTS) drive(zero_txn, 1'b1);
    repeat (300) drive(rand_txn(), 1'b1);

    repeat (10) drive(zero_txn, 1'b0);
    cmp("drain", longint'(keyq.size() + phq.size() + wq.size()), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
